// File: rtl/mem_stage.sv
// mem_stage -- memory pipeline stage between EX/MEM and MEM/WB.
//
// Aligned loads and stores become a single request on a ready/valid data
// bus. Stores are lane-positioned, and load data is extracted and extended.
// While an access is outstanding, the stage asserts stall so that upstream
// holds its in_* inputs steady. Non-memory entries and misaligned accesses
// pass to the MEM/WB registers in one cycle without using the bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_opr_res,    EX/MEM entry: valid, ALU result / byte address,
//   in_opr_b                 store data
//   in_rd, in_rf_en,         writeback control carried to out_*
//   in_wb_sel, in_pc4
//   in_dm_en, in_lsuop       memory access flag, {is_store, funct3}
//   stall                    upstream must hold in_* while high
//   dmem_req, dmem_we,       bus request, write enable, word address,
//   dmem_addr, dmem_be,      byte enables and write data
//   dmem_wdata
//   dmem_ready               bus accepts the request
//   dmem_rvalid, dmem_rdata  bus response (read word or write ack)
//   out_*                    registered MEM/WB payload; out_misalign flags
//                            a misaligned access that was dropped
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_opr_res,
    input  logic [DATA_WIDTH-1:0] in_opr_b,
    input  logic [4:0]            in_rd,
    input  logic                  in_rf_en,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_pc4,
    input  logic                  in_dm_en,
    input  logic [3:0]            in_lsuop,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  out_valid,
    output logic [4:0]            out_rd,
    output logic                  out_rf_en,
    output logic [1:0]            out_wb_sel,
    output logic [DATA_WIDTH-1:0] out_pc4,
    output logic [DATA_WIDTH-1:0] out_opr_res,
    output logic [DATA_WIDTH-1:0] out_lsu_rdata,
    output logic                  out_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic                  aligned;
    logic                  start;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;

    logic [1:0]            lat_off;
    logic [3:0]            lat_lsuop;
    logic [4:0]            lat_rd;
    logic                  lat_rf_en;
    logic [1:0]            lat_wb_sel;
    logic [DATA_WIDTH-1:0] lat_pc4;
    logic [DATA_WIDTH-1:0] lat_opr_res;

    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    // Access size decode; reserved funct3 codes (011/110/111) act as word.
    always_comb begin
        aligned   = (in_opr_res[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = in_opr_b;
        case (in_lsuop[2:0])
            3'b000, 3'b100: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << in_opr_res[1:0];
                wdata_new = {4{in_opr_b[7:0]}};
            end
            3'b001, 3'b101: begin
                aligned   = ~in_opr_res[0];
                be_new    = 4'b0011 << in_opr_res[1:0];
                wdata_new = {2{in_opr_b[15:0]}};
            end
            default: ;
        endcase
    end

    assign start    = (state == IDLE) && in_valid && in_dm_en && aligned;
    assign dmem_req = (state == REQ);
    assign stall    = start || (state == REQ) || ((state == WAIT) && !dmem_rvalid);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = REQ;
            REQ:     if (dmem_ready)  state_next = WAIT;
            WAIT:    if (dmem_rvalid) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Load formatting: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shifted = dmem_rdata >> {lat_off, 3'b000};
        ld_data    = ld_shifted;
        case (lat_lsuop[2:0])
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
        if (lat_lsuop[3]) begin
            ld_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            lat_off       <= '0;
            lat_lsuop     <= '0;
            lat_rd        <= '0;
            lat_rf_en     <= 1'b0;
            lat_wb_sel    <= '0;
            lat_pc4       <= '0;
            lat_opr_res   <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_rf_en     <= 1'b0;
            out_wb_sel    <= '0;
            out_pc4       <= '0;
            out_opr_res   <= '0;
            out_lsu_rdata <= '0;
            out_misalign  <= 1'b0;
        end else begin
            state        <= state_next;
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;

            if (start) begin
                dmem_we     <= in_lsuop[3];
                dmem_addr   <= {in_opr_res[ADDR_WIDTH-1:2], 2'b00};
                dmem_be     <= be_new;
                dmem_wdata  <= wdata_new;
                lat_off     <= in_opr_res[1:0];
                lat_lsuop   <= in_lsuop;
                lat_rd      <= in_rd;
                lat_rf_en   <= in_rf_en;
                lat_wb_sel  <= in_wb_sel;
                lat_pc4     <= in_pc4;
                lat_opr_res <= in_opr_res;
            end else if ((state == IDLE) && in_valid) begin
                // Non-memory op, or a memory op that failed alignment
                // (start already covers the aligned memory case).
                out_valid     <= 1'b1;
                out_misalign  <= in_dm_en;
                out_rf_en     <= in_rf_en && !in_dm_en;
                out_rd        <= in_rd;
                out_wb_sel    <= in_wb_sel;
                out_pc4       <= in_pc4;
                out_opr_res   <= in_opr_res;
                out_lsu_rdata <= '0;
            end

            if ((state == WAIT) && dmem_rvalid) begin
                out_valid     <= 1'b1;
                out_rd        <= lat_rd;
                out_rf_en     <= lat_rf_en;
                out_wb_sel    <= lat_wb_sel;
                out_pc4       <= lat_pc4;
                out_opr_res   <= lat_opr_res;
                out_lsu_rdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// Each entry driven into the stage pushes its expected MEM/WB payload and its
// expected arrival cycle onto a scoreboard. A negedge monitor pops and
// compares the payload whenever out_valid is seen. The stimulus tasks also
// check the bus and stall behaviour cycle by cycle.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_opr_res;
    logic [31:0] in_opr_b;
    logic [4:0]  in_rd;
    logic        in_rf_en;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_pc4;
    logic        in_dm_en;
    logic [3:0]  in_lsuop;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_rf_en;
    logic [1:0]  out_wb_sel;
    logic [31:0] out_pc4;
    logic [31:0] out_opr_res;
    logic [31:0] out_lsu_rdata;
    logic        out_misalign;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned seq    = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        rf_en;
        logic [1:0]  wb_sel;
        logic [31:0] pc4;
        logic [31:0] opr_res;
        logic [31:0] lsu;
        logic        mis;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    mem_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_opr_res   (in_opr_res),
        .in_opr_b     (in_opr_b),
        .in_rd        (in_rd),
        .in_rf_en     (in_rf_en),
        .in_wb_sel    (in_wb_sel),
        .in_pc4       (in_pc4),
        .in_dm_en     (in_dm_en),
        .in_lsuop     (in_lsuop),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .out_valid    (out_valid),
        .out_rd       (out_rd),
        .out_rf_en    (out_rf_en),
        .out_wb_sel   (out_wb_sel),
        .out_pc4      (out_pc4),
        .out_opr_res  (out_opr_res),
        .out_lsu_rdata(out_lsu_rdata),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (out_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                got = sb.pop_front();
                check_eq("out_cycle",     cyc,             got.cyc);
                check_eq("out_rd",        {27'd0, out_rd}, {27'd0, got.rd});
                check_eq("out_rf_en",     {31'd0, out_rf_en}, {31'd0, got.rf_en});
                check_eq("out_wb_sel",    {30'd0, out_wb_sel}, {30'd0, got.wb_sel});
                check_eq("out_pc4",       out_pc4,         got.pc4);
                check_eq("out_opr_res",   out_opr_res,     got.opr_res);
                check_eq("out_lsu_rdata", out_lsu_rdata,   got.lsu);
                check_eq("out_misalign",  {31'd0, out_misalign}, {31'd0, got.mis});
            end
        end
    end

    // Drive common entry fields; caller sets in_dm_en / in_lsuop / in_opr_b.
    task automatic drive_entry(input logic [31:0] res, input logic rf_en);
        seq++;
        in_valid   = 1'b1;
        in_opr_res = res;
        in_rd      = seq[4:0];
        in_rf_en   = rf_en;
        in_wb_sel  = seq[1:0];
        in_pc4     = 32'h1000 + (seq << 2);
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic do_alu(input logic [31:0] res);
        in_dm_en = 1'b0;
        in_lsuop = 4'b0010;
        in_opr_b = ~res;
        drive_entry(res, 1'b1);
        sb.push_back('{rd: in_rd, rf_en: 1'b1, wb_sel: in_wb_sel, pc4: in_pc4,
                       opr_res: res, lsu: 32'd0, mis: 1'b0, cyc: cyc + 1});
        @(negedge clk);
        check_eq("alu_stall", {31'd0, stall}, 32'd0);
        check_eq("alu_req",   {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_misalign(input logic [3:0] lsuop, input logic [31:0] addr);
        in_dm_en = 1'b1;
        in_lsuop = lsuop;
        in_opr_b = 32'hA5A5_5A5A;
        drive_entry(addr, 1'b1);
        sb.push_back('{rd: in_rd, rf_en: 1'b0, wb_sel: in_wb_sel, pc4: in_pc4,
                       opr_res: addr, lsu: 32'd0, mis: 1'b1, cyc: cyc + 1});
        @(negedge clk);
        check_eq("mis_stall", {31'd0, stall}, 32'd0);
        check_eq("mis_req",   {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        check_eq("mis_req_next", {31'd0, dmem_req}, 32'd0);
        in_valid = 1'b0;
    endtask

    // Memory access: ready after d wait cycles, response one cycle after.
    // With stray set, a bogus dmem_rvalid is shown while still in REQ.
    task automatic do_mem(input logic [3:0] lsuop, input logic [31:0] addr,
                          input logic [31:0] opb, input logic [31:0] rdata,
                          input logic [31:0] exp_lsu, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input bit chk_w,
                          input int unsigned d, input bit stray);
        in_dm_en = 1'b1;
        in_lsuop = lsuop;
        in_opr_b = opb;
        drive_entry(addr, !lsuop[3]);
        sb.push_back('{rd: in_rd, rf_en: !lsuop[3], wb_sel: in_wb_sel, pc4: in_pc4,
                       opr_res: addr, lsu: exp_lsu, mis: 1'b0, cyc: cyc + 3 + d});
        @(negedge clk);
        check_eq("idle_stall", {31'd0, stall}, 32'd1);
        check_eq("idle_req",   {31'd0, dmem_req}, 32'd0);
        for (int i = 0; i <= int'(d); i++) begin
            @(posedge clk); #1;
            dmem_ready  = (i == int'(d));
            dmem_rvalid = stray && (i < int'(d));
            dmem_rdata  = 32'h5555_AAAA;
            @(negedge clk);
            check_eq("req_req",   {31'd0, dmem_req}, 32'd1);
            check_eq("req_stall", {31'd0, stall}, 32'd1);
            check_eq("req_ovld",  {31'd0, out_valid}, 32'd0);
            check_eq("req_addr",  dmem_addr, {addr[31:2], 2'b00});
            check_eq("req_we",    {31'd0, dmem_we}, {31'd0, lsuop[3]});
            if (chk_w) begin
                check_eq("req_be",    {28'd0, dmem_be}, {28'd0, exp_be});
                check_eq("req_wdata", dmem_wdata, exp_wdata);
            end
        end
        @(posedge clk); #1;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        check_eq("wait_req",   {31'd0, dmem_req}, 32'd0);
        check_eq("wait_stall", {31'd0, stall}, 32'd0);
        check_eq("wait_ovld",  {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        in_valid    = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_opr_res  = 32'd0;
        in_opr_b    = 32'd0;
        in_rd       = 5'd0;
        in_rf_en    = 1'b0;
        in_wb_sel   = 2'd0;
        in_pc4      = 32'd0;
        in_dm_en    = 1'b0;
        in_lsuop    = 4'd0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ovld",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_req",   {31'd0, dmem_req}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_mis",   {31'd0, out_misalign}, 32'd0);
        check_eq("rst_rfen",  {31'd0, out_rf_en}, 32'd0);
        check_eq("rst_lsu",   out_lsu_rdata, 32'd0);
        check_eq("rst_addr",  dmem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_alu(32'h1234_5678);
        // LW / LB / LBU / LH / LHU
        do_mem(4'b0010, 32'h100, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 0, 1'b0);
        check_eq("lw_be", {28'd0, dmem_be}, 32'h0000_000F);
        do_mem(4'b0000, 32'h103, 32'd0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b0000, 32'd0, 1'b0, 0, 1'b0);
        do_mem(4'b0100, 32'h103, 32'd0, 32'h80FF_FFFF, 32'h0000_0080, 4'b0000, 32'd0, 1'b0, 0, 1'b0);
        do_mem(4'b0101, 32'h102, 32'd0, 32'h80FF_FFFF, 32'h0000_80FF, 4'b0000, 32'd0, 1'b0, 0, 1'b0);
        do_mem(4'b0001, 32'h102, 32'd0, 32'h80FF_1234, 32'hFFFF_80FF, 4'b0000, 32'd0, 1'b0, 0, 1'b0);
        do_mem(4'b0000, 32'h101, 32'd0, 32'h1122_7F44, 32'h0000_007F, 4'b0000, 32'd0, 1'b0, 0, 1'b0);
        // SB / SH / SW, response data must not reach out_lsu_rdata
        do_mem(4'b1000, 32'h201, 32'h0000_00AB, 32'hFFFF_FFFF, 32'd0, 4'b0010, 32'hABAB_ABAB, 1'b1, 0, 1'b0);
        do_mem(4'b1001, 32'h202, 32'h1234_CDEF, 32'hFFFF_FFFF, 32'd0, 4'b1100, 32'hCDEF_CDEF, 1'b1, 0, 1'b0);
        do_mem(4'b1010, 32'h300, 32'h1122_3344, 32'hFFFF_FFFF, 32'd0, 4'b1111, 32'h1122_3344, 1'b1, 0, 1'b0);
        // Misaligned accesses, including reserved funct3 treated as word
        do_misalign(4'b0010, 32'h102);
        do_misalign(4'b0001, 32'h101);
        do_misalign(4'b1011, 32'h201);
        do_misalign(4'b1101, 32'h203);
        // Slow bus with stray responses in REQ, then back-to-back ALU op
        do_mem(4'b1010, 32'h400, 32'hCAFE_F00D, 32'h0, 32'd0, 4'b1111, 32'hCAFE_F00D, 1'b1, 4, 1'b1);
        do_alu(32'h0BAD_CAFE);
        do_alu(32'h0000_0001);

        // Reset while waiting for a response
        in_dm_en = 1'b1;
        in_lsuop = 4'b0010;
        in_opr_b = 32'd0;
        drive_entry(32'h500, 1'b1);
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("rw_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rw_rst_req",  {31'd0, dmem_req}, 32'd0);
        check_eq("rw_rst_ovld", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_rel_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        @(negedge clk);
        check_eq("rw_late_stall", {31'd0, stall}, 32'd0);
        check_eq("rw_late_req",   {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        @(negedge clk);
        check_eq("rw_late_ovld", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        do_mem(4'b0010, 32'h600, 32'd0, 32'h0123_4567, 32'h0123_4567, 4'b1111, 32'd0, 1'b1, 1, 1'b0);
        do_alu(32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_left", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
